// File: rtl/uart_rx_cmd.sv
// ============================================================================
// Module      : uart_rx_cmd
// Description : 8N1 UART receiver for BLE command bytes, with rdy/clr_rdy
//               handshake. Optional even-parity bit via UART_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_cmd #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       overrun,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam logic [15:0] c_RELOAD = 16'(BAUD_DIV - 1);
    localparam logic [15:0] c_HALF   = 16'(BAUD_DIV / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BRK    = 3'd5
    } state_t;

    state_t      r_state;
    logic        r_rx_meta;
    logic        r_rx_s;
    logic [15:0] r_baud_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_accept;
    logic [7:0]  r_rx_data;
    logic        r_rdy;
    logic        r_overrun;
    logic        r_frame_err;
    logic        r_busy;
`ifdef UART_RX_PARITY_EN
    logic        r_par_bad;
    logic        r_parity_err;
`endif

    logic w_sample;
    assign w_sample = (r_baud_cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_baud_cnt  <= 16'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_accept    <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rdy       <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_meta   <= RX;
            r_rx_s      <= r_rx_meta;
            r_frame_err <= 1'b0;
            r_accept    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif

            // A byte landing in the same cycle as clr_rdy takes priority.
            if (r_accept) begin
                r_rx_data <= r_shift;
                r_rdy     <= 1'b1;
                r_overrun <= clr_rdy ? 1'b0 : (r_rdy | r_overrun);
            end else if (clr_rdy) begin
                r_rdy     <= 1'b0;
                r_overrun <= 1'b0;
            end

            if (r_state != S_IDLE && r_state != S_BRK) begin
                r_baud_cnt <= w_sample ? c_RELOAD : r_baud_cnt - 16'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state    <= S_START;
                        r_busy     <= 1'b1;
                        r_baud_cnt <= c_HALF;
                    end
                end
                S_START: begin
                    if (w_sample) begin
                        if (!r_rx_s) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= 3'd0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_sample) begin
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_sample) begin
                        r_par_bad <= (r_rx_s != ^r_shift);
                        r_state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_sample) begin
`ifdef UART_RX_PARITY_EN
                        r_parity_err <= r_par_bad;
`endif
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            r_accept <= ~r_par_bad;
`else
                            r_accept <= 1'b1;
`endif
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BRK;
                        end
                    end
                end
                // Held-low line must return high before a new start is seen.
                S_BRK: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = r_rx_data;
    assign rdy       = r_rdy;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_cmd.sv
// ============================================================================
// Module      : tb_uart_rx_cmd
// Description : Self-checking bench for uart_rx_cmd using an event-schedule
//               model derived from frame timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_cmd;

    localparam int BD = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    // Edge (after the driving edge) at which the stop bit is sampled.
    localparam int STOP_EDGE = 3 + BD / 2 + NB * BD;
    localparam int LAT       = 2 + BD / 2 + NB * BD + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RX = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rdy, overrun, frame_err, parity_err, busy;

    uart_rx_cmd #(.BAUD_DIV(BD)) dut (
        .clk(clk), .rst(rst), .RX(RX), .clr_rdy(clr_rdy),
        .rx_data(rx_data), .rdy(rdy), .overrun(overrun),
        .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    int ev_busy_on = -1, ev_busy_off = -1, ev_ferr = -1, ev_perr = -1, ev_accept = -1;
    logic [7:0] ev_data = 8'h00;
    int last_k = 0;

    logic       exp_rdy = 1'b0, exp_ovr = 1'b0, exp_busy = 1'b0, exp_ferr = 1'b0, exp_perr = 1'b0;
    logic [7:0] exp_data = 8'h00;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        exp_ferr <= 1'b0;
        exp_perr <= 1'b0;
        if (rst) begin
            exp_rdy  <= 1'b0;
            exp_ovr  <= 1'b0;
            exp_busy <= 1'b0;
            exp_data <= 8'h00;
        end else begin
            if (cyc + 1 == ev_busy_on)  exp_busy <= 1'b1;
            if (cyc + 1 == ev_busy_off) exp_busy <= 1'b0;
            if (cyc + 1 == ev_ferr)     exp_ferr <= 1'b1;
            if (cyc + 1 == ev_perr)     exp_perr <= 1'b1;
            if (cyc + 1 == ev_accept) begin
                exp_data <= ev_data;
                exp_rdy  <= 1'b1;
                exp_ovr  <= clr_rdy ? 1'b0 : (exp_rdy | exp_ovr);
            end else if (clr_rdy) begin
                exp_rdy <= 1'b0;
                exp_ovr <= 1'b0;
            end
        end
    end

    int   ferr_cnt = 0, perr_cnt = 0, rise_cyc = 0;
    logic rdy_prev = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            checks = checks + 1;
            if ({rdy, overrun, busy, frame_err, parity_err, rx_data} !==
                {exp_rdy, exp_ovr, exp_busy, exp_ferr, exp_perr, exp_data}) begin
                errors = errors + 1;
                $display("FAIL cycle_model @%0d: got rdy=%b ovr=%b busy=%b ferr=%b perr=%b data=%02h, expected rdy=%b ovr=%b busy=%b ferr=%b perr=%b data=%02h",
                         cyc, rdy, overrun, busy, frame_err, parity_err, rx_data,
                         exp_rdy, exp_ovr, exp_busy, exp_ferr, exp_perr, exp_data);
            end
            if (frame_err) ferr_cnt = ferr_cnt + 1;
            if (parity_err) perr_cnt = perr_cnt + 1;
            if (rdy && !rdy_prev) rise_cyc = cyc;
            rdy_prev = rdy;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        clr_rdy = 1'b1;
        @(posedge clk); #1;
        clr_rdy = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok, input int rst_bit);
        @(posedge clk); #1;
        RX          = 1'b0;
        last_k      = cyc;
        ev_data     = b;
        ev_busy_on  = cyc + 3;
        ev_busy_off = stop_ok ? cyc + STOP_EDGE : -1;
        ev_ferr     = stop_ok ? -1 : cyc + STOP_EDGE;
        ev_perr     = par_ok ? -1 : cyc + STOP_EDGE;
        ev_accept   = (stop_ok && par_ok) ? cyc + STOP_EDGE + 1 : -1;
        for (int i = 0; i < 8; i++) begin
            wait_cycles(BD);
            RX = b[i];
            if (i == rst_bit) begin
                wait_cycles(BD / 2);
                ev_busy_on = -1; ev_busy_off = -1; ev_ferr = -1; ev_perr = -1; ev_accept = -1;
                rst = 1'b1;
                RX  = 1'b1;
                wait_cycles(1);
                rst = 1'b0;
                return;
            end
        end
`ifdef UART_RX_PARITY_EN
        wait_cycles(BD);
        RX = (^b) ^ !par_ok;
`endif
        wait_cycles(BD);
        RX = stop_ok;
        if (stop_ok) begin
            wait_cycles(BD);
        end else begin
            wait_cycles(3 * BD);
            RX = 1'b1;
            ev_busy_off = cyc + 3;
            wait_cycles(BD);
        end
    endtask

    task automatic false_start();
        @(posedge clk); #1;
        RX = 1'b0;
        ev_busy_on = cyc + 3;
        ev_busy_off = cyc + 3 + BD / 2;
        ev_ferr = -1; ev_perr = -1; ev_accept = -1;
        wait_cycles(4);
        RX = 1'b1;
        wait_cycles(BD);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        wait_cycles(3);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_rdy", {31'd0, rdy}, 32'd0);
        check("reset_data", {24'd0, rx_data}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        wait_cycles(5);

        // Single byte, latency and acknowledge
        ferr_cnt = 0;
        send_frame(8'h67, 1'b1, 1'b1, -1);
        check("latency", rise_cyc - (last_k + 1), LAT);
        check("byte_67", {24'd0, rx_data}, 32'h67);
        check("no_ferr", ferr_cnt, 0);
        pulse_clr();
        check("clr_rdy", {31'd0, rdy}, 32'd0);

        // Overrun on two unacknowledged bytes
        send_frame(8'h67, 1'b1, 1'b1, -1);
        send_frame(8'h73, 1'b1, 1'b1, -1);
        check("ovr_data", {24'd0, rx_data}, 32'h73);
        check("ovr_flag", {30'd0, rdy, overrun}, 32'h3);
        pulse_clr();
        check("ovr_clr", {30'd0, rdy, overrun}, 32'h0);

        // False start, then clr_rdy colliding with a byte accept
        false_start();
        check("false_busy", {31'd0, busy}, 32'd0);
        check("false_data", {24'd0, rx_data}, 32'h73);
        send_frame(8'h11, 1'b1, 1'b1, -1);
        fork
            send_frame(8'h55, 1'b1, 1'b1, -1);
            begin
                repeat (STOP_EDGE + 1) @(posedge clk);
                #1 clr_rdy = 1'b1;
                @(posedge clk);
                #1 clr_rdy = 1'b0;
            end
        join
        check("collide", {22'd0, rdy, overrun, rx_data}, {22'd0, 2'b10, 8'h55});

        // Stop bit held low: framing error then break recovery
        pulse_clr();
        ferr_cnt = 0;
        send_frame(8'hA5, 1'b0, 1'b1, -1);
        check("ferr_pulse", ferr_cnt, 1);
        check("ferr_rdy", {31'd0, rdy}, 32'd0);
        check("ferr_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h67, 1'b1, 1'b1, -1);
        check("after_brk", {23'd0, rdy, rx_data}, {23'd0, 1'b1, 8'h67});

        // Reset during bit 4
        send_frame(8'h67, 1'b1, 1'b1, 4);
        check("midrst", {20'd0, rdy, overrun, busy, frame_err, rx_data}, 32'd0);
        wait_cycles(BD);
        send_frame(8'h67, 1'b1, 1'b1, -1);
        check("post_rst", {23'd0, rdy, rx_data}, {23'd0, 1'b1, 8'h67});

`ifdef UART_RX_PARITY_EN
        pulse_clr();
        perr_cnt = 0;
        send_frame(8'h67, 1'b1, 1'b1, -1);
        check("par_good", {23'd0, rdy, rx_data}, {23'd0, 1'b1, 8'h67});
        pulse_clr();
        send_frame(8'h73, 1'b1, 1'b0, -1);
        check("par_pulse", perr_cnt, 1);
        check("par_rdy", {31'd0, rdy}, 32'd0);
`endif

        wait_cycles(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_cmd.md
Name: uart_rx_cmd

Overview:
- 8N1 UART receiver for the command path from the BLE module: 'g' (0x67) = go, 's' (0x73) = stop.
- Pairs with UART_tx, which drives the TX end of the same line.
- Samples the asynchronous RX pin and validates start and stop bits.
- Presents each received byte with a rdy/clr_rdy handshake to the command/auth logic inside Segway.

Parameters:
- BAUD_DIV, 2604, clk cycles per bit (50 MHz / 19200 baud); legal range 8..65535.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- RX  in  1  asynchronous serial input; idles high.
- clr_rdy  in  1  consumer acknowledge; clears rdy and overrun.
- rx_data  out  8  last accepted byte.
- rdy  out  1  byte available; level, sticky.
- overrun  out  1  sticky; a byte completed while rdy=1.
- frame_err  out  1  one-cycle pulse; stop bit sampled low.
- parity_err  out  1  one-cycle pulse (see Optional Feature).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset and clock: single clk domain. All state is reset synchronously when rst=1 at a posedge.
- Reset values: rx_data=0x00, rdy=0, overrun=0, frame_err=0, parity_err=0, busy=0. State=IDLE. Both synchronizer flops =1.
- Input sync: RX passes through 2 flops (rx_s). All decisions use rx_s only.
- Baud counter: 16-bit down-counter. A sample event occurs when it reaches 0; it then reloads with BAUD_DIV-1.
- IDLE: when rx_s=0, go to START and load the counter with BAUD_DIV/2-1 (mid-bit alignment).
- START, at sample event:
  - rx_s=0: go to DATA, bit_cnt=0.
  - rx_s=1: false start; go to IDLE with no flags raised.
- DATA, at each sample event:
  - Shift right, rx_s into bit 7 (LSB first), bit_cnt++.
  - After the 8th bit, go to STOP (or PARITY when the feature is enabled).
- STOP, at sample event:
  - rx_s=1: go to IDLE.
    - Next cycle: rx_data<=shift, rdy<=1.
    - If rdy was already 1, also overrun<=1, and rx_data is still overwritten.
  - rx_s=0: frame_err pulses for 1 cycle. rx_data and rdy are unchanged. Go to BRK.
- BRK: wait until rx_s=1, then go to IDLE. This prevents a held-low line from retriggering.
- clr_rdy: rdy<=0 and overrun<=0 on the next cycle.
  - If clr_rdy coincides with a byte-accept cycle, the new byte wins: rdy=1 and overrun=0.
- Latency: from the RX falling edge at the pin to rdy=1 is 2 + BAUD_DIV/2 + 9*BAUD_DIV + 1 cycles (±1 from sync phase).
- Reset mid-frame: the partial byte is discarded, rdy=0, and the block returns to IDLE. rx_s=1 for 2 cycles after reset, so a line held low is seen only after that.
- busy=0 only in IDLE. BRK counts as busy.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples one even-parity bit.
  - On mismatch, parity_err pulses for 1 cycle at the stop-bit sample and the byte is not accepted (rdy unchanged). The FSM still checks the stop bit for BRK.
  - Latency grows by BAUD_DIV.
- Undefined: 8N1 only, and parity_err is tied to 0.

Test Plan:
- Send 0x67 via UART_tx (BAUD_DIV=16 in both) -> rdy rises at the stated latency, rx_data=0x67, frame_err=0. Then pulse clr_rdy -> rdy=0 next cycle.
- Send 0x67 then 0x73 with no clr_rdy -> rx_data=0x73, rdy=1, overrun=1. Then clr_rdy -> both 0.
- RX low for 4 cycles then high (BAUD_DIV=16) -> returns to IDLE with busy=0, and rdy, frame_err and rx_data are unchanged. A following valid 0x55 is received correctly.
- Frame 0xA5 with stop bit forced 0 for 3 bit-times -> one-cycle frame_err, rdy stays 0, busy stays 1 until RX returns high. A subsequent 0x67 is received.
- Assert rst during bit 4 of 0x67 -> all outputs 0 next cycle. A byte sent after rst deasserts and the line idles for 1 bit-time is received correctly.
- With UART_RX_PARITY_EN: 0x67 with correct even parity -> rdy=1. With flipped parity -> parity_err pulse and rdy=0.
